inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter DEPTH, default 4, word-buffer entries (power of 2, >=2).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a load session at base_addr.
REQ-006 base_addr  input  ADDR_W  first program-memory address of session.
REQ-007 e_valid  input  1  field tuple valid.
REQ-008 e_ready  output  1  tuple accepted when e_valid && e_ready.
REQ-009 e_op  input  3  opcode (0 = add, 7 = jump, others pass through).
REQ-010 e_rs  input  2  source register.
REQ-011 e_rd  input  2  destination register.
REQ-012 e_a  input  16  immediate/address field.
REQ-013 e_last  input  1  tuple is final of session.
REQ-014 pm_we  output  1  program-memory write request.
REQ-015 pm_ready  input  1  memory accepts write when pm_we && pm_ready.
REQ-016 pm_addr  output  ADDR_W  write address.
REQ-017 pm_wdata  output  32  encoded instruction word.
REQ-018 busy  output  1  session in progress (state != IDLE).
REQ-019 done  output  1  one-cycle pulse at session end.
REQ-020 count  output  ADDR_W+1  words written in current/last session.
REQ-021 wrap_err  output  1  sticky: address wrapped during session.

Function
REQ-022 Word format: [31:27]=0, [26:24]=e_op, [23:22]=0, [21:20]=e_rs, [19:18]=0, [17:16]=e_rd, [15:0]=e_a; inverse of decoder field extraction.
REQ-023 FSM states IDLE, LOAD, DRAIN, FIN.
REQ-024 IDLE: start=1 -> LOAD next cycle; pm_addr<=base_addr, count<=0, wrap_err<=0; start ignored in all other states.
REQ-025 LOAD: e_ready = !full; accepted tuple encoded and pushed same edge; accepted with e_last=1 -> DRAIN.
REQ-026 DRAIN: e_ready=0; FIFO empty and no write pending -> FIN.
REQ-027 LOAD with e_last word accepted into empty FIFO still passes through DRAIN (no state skip).
REQ-028 FIN: done=1 for exactly one cycle -> IDLE.
REQ-029 e_ready=0 in IDLE, DRAIN, FIN.
REQ-030 pm_we = FIFO non-empty (LOAD or DRAIN); pm_wdata = FIFO head.
REQ-031 Latency: tuple accepted at edge N appears on pm_wdata/pm_we after edge N (earliest write completion at edge N+1).
REQ-032 pm_we, pm_addr, pm_wdata held stable while pm_we && !pm_ready.
REQ-033 On write completion: pop, pm_addr<=pm_addr+1 (mod 2^ADDR_W), count<=count+1.
REQ-034 Completion with pm_addr = 2^ADDR_W-1: pm_addr wraps to 0, wrap_err<=1 (sticky until next start).
REQ-035 Push and pop same cycle when not full: both occur, occupancy unchanged.
REQ-036 Full: e_ready=0; no tuple dropped; same-cycle pop does not raise e_ready (registered full flag).
REQ-037 count saturation not required: max session length 2^ADDR_W words.

Reset
REQ-038 rst_n low: state=IDLE, FIFO empty, pm_we=0, pm_addr=0, pm_wdata=0, count=0, wrap_err=0, done=0, busy=0, e_ready=0.
REQ-039 Reset mid-session discards buffered words; no write issued after rst_n deasserts until next start.

Structure
REQ-040 Shared package holds field bit positions, OP_ADD=3'd0, OP_JUMP=3'd7, word width 32, FSM state type.
REQ-041 One sub-module inst_fifo (synchronous, DEPTH x 32, full/empty, registered flags).

Verification
REQ-042 start, base_addr=0x10; tuples (op0,rs1,rd2,a=0x1234),(op7,rs0,rd0,a=0x0040,last), pm_ready=1 -> writes 0x10:0x00121234, 0x11:0x07000040; done pulse; count=2.
REQ-043 pm_ready=0 for 10 cycles while 6 tuples offered -> e_ready low after 4 accepted; pm_* stable; all 6 written in order after pm_ready=1.
REQ-044 base_addr=0xFE, 3 words -> addresses 0xFE,0xFF,0x00; wrap_err=1; count=3.
REQ-045 rst_n low after 2 of 4 words written -> all outputs at reset values; pm_we stays 0 until new start.
REQ-046 start asserted during LOAD with base_addr=0x80 -> ignored; addresses continue sequentially.
REQ-047 Single tuple with e_last, pm_ready=1 -> states LOAD->DRAIN->FIN->IDLE; done one cycle; busy low after.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared field layout, opcode constants and FSM state type for the instruction encoder.
package inst_encoder_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned IMM_W   = 16;

    localparam int unsigned OP_LSB  = 24;
    localparam int unsigned RS_LSB  = 20;
    localparam int unsigned RD_LSB  = 16;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_JUMP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Pack the field tuple into an instruction word; unused bits stay zero.
    function automatic logic [WORD_W-1:0] encode_word(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd,
        input logic [IMM_W-1:0] a
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB  +: OP_W]  = op;
        w[RS_LSB  +: REG_W] = rs;
        w[RD_LSB  +: REG_W] = rd;
        w[IMM_LSB +: IMM_W] = a;
        return w;
    endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Synchronous word buffer with registered full/empty flags.
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Next occupancy, used to register the flags one edge ahead.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Storage, pointers and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt_q <= cnt_d;
            full  <= (cnt_d == CNT_W'(DEPTH));
            empty <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes field tuples into instruction words and streams them into program memory.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [OP_W-1:0]   e_op,
    input  logic [REG_W-1:0]  e_rs,
    input  logic [REG_W-1:0]  e_rd,
    input  logic [IMM_W-1:0]  e_a,
    input  logic              e_last,
    output logic              pm_we,
    input  logic              pm_ready,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [WORD_W-1:0] pm_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              wrap_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] push_word;

    // Handshakes are decoded purely from flops: state and the registered FIFO flags.
    assign e_ready   = (state == ST_LOAD) && !fifo_full;
    assign push      = e_valid && e_ready;
    assign pm_we     = !fifo_empty;
    assign pop       = pm_we && pm_ready;
    assign push_word = encode_word(e_op, e_rs, e_rd, e_a);

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_word),
        .rdata (pm_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Session FSM plus address/count/wrap bookkeeping on each completed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pm_addr  <= '0;
            count    <= '0;
            wrap_err <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                pm_addr <= pm_addr + ADDR_W'(1);
                count   <= count + CNT_W'(1);
                if (pm_addr == '1) begin
                    wrap_err <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        pm_addr  <= base_addr;
                        count    <= '0;
                        wrap_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (push && e_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        e_valid;
    logic        e_ready;
    logic [2:0]  e_op;
    logic [1:0]  e_rs;
    logic [1:0]  e_rd;
    logic [15:0] e_a;
    logic        e_last;
    logic        pm_we;
    logic        pm_ready;
    logic [7:0]  pm_addr;
    logic [31:0] pm_wdata;
    logic        busy;
    logic        done;
    logic [8:0]  count;
    logic        wrap_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .e_valid   (e_valid),
        .e_ready   (e_ready),
        .e_op      (e_op),
        .e_rs      (e_rs),
        .e_rd      (e_rd),
        .e_a       (e_a),
        .e_last    (e_last),
        .pm_we     (pm_we),
        .pm_ready  (pm_ready),
        .pm_addr   (pm_addr),
        .pm_wdata  (pm_wdata),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .wrap_err  (wrap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program-memory model: log every completed write.
    always @(posedge clk) begin
        if (rst_n && pm_we && pm_ready) begin
            wr_addr.push_back(pm_addr);
            wr_data.push_back(pm_wdata);
        end
    end

    function automatic logic [31:0] exp_word(input logic [2:0] op, input logic [1:0] rs,
                                             input logic [1:0] rd, input logic [15:0] a);
        return {5'b0, op, 2'b0, rs, 2'b0, rd, a};
    endfunction

    task automatic do_start(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Offer one tuple from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rd,
                        input logic [15:0] a, input logic last);
        int n;
        n = 0;
        e_valid = 1'b1; e_op = op; e_rs = rs; e_rd = rd; e_a = a; e_last = last;
        while (!e_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout: e_ready=%0b after %0d cycles, required 1", e_ready, n);
        end else begin
            @(negedge clk);
        end
        e_valid = 1'b0;
        e_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%0b, required 1", done);
        end
    endtask

    task automatic check_writes(input string name, input logic [7:0] base, input int n,
                                input logic [31:0] words[$]);
        logic [7:0] ea;
        checks++;
        if (wr_addr.size() != n) begin
            errors++;
            $display("FAIL %s_nwrites: got %0d, required %0d", name, wr_addr.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            ea = base + 8'(i);
            checks++;
            if (wr_addr[i] !== ea || wr_data[i] !== words[i]) begin
                errors++;
                $display("FAIL %s_write%0d: got %h:%h, required %h:%h",
                         name, i, wr_addr[i], wr_data[i], ea, words[i]);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (pm_we !== 1'b0 || pm_addr !== 8'h00 || pm_wdata !== 32'h0 || count !== 9'd0 ||
            wrap_err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || e_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: we=%b addr=%h wdata=%h count=%0d wrap=%b done=%b busy=%b rdy=%b, required all zero",
                     name, pm_we, pm_addr, pm_wdata, count, wrap_err, done, busy, e_ready);
        end
    endtask

    task automatic test_reset();
        check_reset_vals("reset_values");
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d, required %0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w[$];
        wr_addr.delete(); wr_data.delete();
        pm_ready = 1'b1;
        do_start(8'h10);
        checks++;
        if (busy !== 1'b1 || e_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_load: busy=%b e_ready=%b, required 1 1", busy, e_ready);
        end
        send(3'd0, 2'd1, 2'd2, 16'h1234, 1'b0);
        send(3'd7, 2'd0, 2'd0, 16'h0040, 1'b1);
        wait_done();
        checks++;
        if (count !== 9'd2) begin
            errors++;
            $display("FAIL basic_count: got %0d, required 2", count);
        end
        w = '{32'h00121234, 32'h07000040};
        check_writes("basic", 8'h10, 2, w);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[$];
        logic [31:0] w0;
        int k;
        int bad;
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 6; i++) w.push_back(exp_word(3'(i), 2'(i), 2'(i + 1), 16'h0100 + 16'(i)));
        w0 = w[0];
        pm_ready = 1'b0;
        do_start(8'h20);
        k = 0; bad = 0;
        e_valid = 1'b1; e_op = 3'd0; e_rs = 2'd0; e_rd = 2'd1; e_a = 16'h0100; e_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            acc = e_valid && e_ready;
            @(negedge clk);
            if (acc) begin
                k++;
                e_op = 3'(k); e_rs = 2'(k); e_rd = 2'(k + 1); e_a = 16'h0100 + 16'(k);
                e_last = (k == 5);
            end
            if (pm_we !== 1'b1 || pm_addr !== 8'h20 || pm_wdata !== w0) bad++;
        end
        checks++;
        if (k != 4 || e_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepted=%0d e_ready=%b, required 4 0", k, e_ready);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable: unstable cycles=%0d, required 0", bad);
        end
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL bp_nowrite: got %0d writes, required 0", wr_addr.size());
        end
        pm_ready = 1'b1;
        send(3'd4, 2'd0, 2'd1, 16'h0104, 1'b0);
        send(3'd5, 2'd1, 2'd2, 16'h0105, 1'b1);
        wait_done();
        checks++;
        if (count !== 9'd6) begin
            errors++;
            $display("FAIL bp_count: got %0d, required 6", count);
        end
        check_writes("bp", 8'h20, 6, w);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] w[$];
        wr_addr.delete(); wr_data.delete();
        pm_ready = 1'b1;
        do_start(8'hFE);
        send(3'd1, 2'd3, 2'd0, 16'hAAAA, 1'b0);
        send(3'd2, 2'd2, 2'd1, 16'h5555, 1'b0);
        send(3'd7, 2'd1, 2'd3, 16'hFFFF, 1'b1);
        wait_done();
        w = '{32'h01305AAA_ ^ 32'h00005AAA ^ 32'h0000AAAA, 32'h02215555, 32'h0713FFFF};
        checks++;
        if (count !== 9'd3 || wrap_err !== 1'b1) begin
            errors++;
            $display("FAIL wrap_flags: count=%0d wrap_err=%b, required 3 1", count, wrap_err);
        end
        checks++;
        if (wr_addr.size() != 3 || wr_addr[0] !== 8'hFE || wr_addr[1] !== 8'hFF || wr_addr[2] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_addrs: got %0d writes, required FE FF 00", wr_addr.size());
        end
        checks++;
        if (wr_data.size() != 3 || wr_data[0] !== w[0] || wr_data[1] !== w[1] || wr_data[2] !== w[2]) begin
            errors++;
            $display("FAIL wrap_data: data mismatch over %0d writes", wr_data.size());
        end
        @(negedge clk);
        checks++;
        if (wrap_err !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sticky: got %b, required 1", wrap_err);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] w[$];
        wr_addr.delete(); wr_data.delete();
        pm_ready = 1'b1;
        do_start(8'h40);
        checks++;
        if (wrap_err !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL start_clear: wrap_err=%b count=%0d, required 0 0", wrap_err, count);
        end
        send(3'd3, 2'd1, 2'd1, 16'h0011, 1'b0);
        start = 1'b1; base_addr = 8'h80;
        send(3'd4, 2'd2, 2'd2, 16'h0022, 1'b0);
        start = 1'b0;
        send(3'd7, 2'd3, 2'd3, 16'h0033, 1'b1);
        wait_done();
        w = '{32'h03110011, 32'h04220022, 32'h07330033};
        check_writes("start_ign", 8'h40, 3, w);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        wr_addr.delete(); wr_data.delete();
        pm_ready = 1'b0;
        do_start(8'h30);
        for (int i = 0; i < 4; i++) send(3'(i), 2'(i), 2'(i), 16'(i), 1'b0);
        pm_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL rstmid_written: got %0d, required 2", wr_addr.size());
        end
        check_reset_vals("rstmid_values");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) @(negedge clk);
        checks++;
        if (wr_addr.size() != 2 || pm_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: writes=%0d pm_we=%b busy=%b, required 2 0 0",
                     wr_addr.size(), pm_we, busy);
        end
    endtask

    task automatic test_single();
        pm_ready = 1'b1;
        do_start(8'h50);
        send(3'd0, 2'd0, 2'd0, 16'hBEEF, 1'b1);
        checks++;
        if (dut.state !== ST_DRAIN || e_ready !== 1'b0 || pm_we !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_drain1: state=%0d rdy=%b we=%b done=%b, required 2 0 1 0",
                     dut.state, e_ready, pm_we, done);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== ST_DRAIN || pm_we !== 1'b0 || done !== 1'b0 || count !== 9'd1) begin
            errors++;
            $display("FAIL single_drain2: state=%0d we=%b done=%b count=%0d, required 2 0 0 1",
                     dut.state, pm_we, done, count);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== ST_FIN || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_fin: state=%0d done=%b busy=%b, required 3 1 1", dut.state, done, busy);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== ST_IDLE || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: state=%0d done=%b busy=%b, required 0 0 0", dut.state, done, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; e_valid = 1'b0; e_op = '0;
        e_rs = '0; e_rd = '0; e_a = '0; e_last = 1'b0; pm_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
